// File: rtl/ahb_ram_pkg.sv
// Shared AHB-Lite encodings and the byte-lane decode for the FPGA block-RAM interface.
package ahb_ram_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    ST_OKAY,
    ST_ERR1,
    ST_ERR2
  } resp_state_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  function automatic logic [3:0] lane_decode(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] lanes;
    case (size)
      HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
      HSIZE_HALF: lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    lanes = 4'b1111;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/ahb_ram_wbuf.sv
// One-entry posted-write buffer with the read-data byte-merge for read-after-write hazards.
module ahb_ram_wbuf
  import ahb_ram_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          flush,
  input  logic [AW-3:0] ld_addr,
  input  logic [3:0]    ld_lanes,
  input  logic [31:0]   ld_data,
  input  logic          rd_phase,
  input  logic [AW-3:0] rd_addr,
  input  logic [31:0]   ram_rdata,
  output logic          buf_valid,
  output logic [AW-3:0] buf_addr,
  output logic [3:0]    buf_lanes,
  output logic [31:0]   buf_data,
  output logic [31:0]   rdata
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_lanes <= '0;
      buf_data  <= '0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_addr  <= ld_addr;
      buf_lanes <= ld_lanes;
      buf_data  <= ld_data;
    end else if (flush) begin
      buf_valid <= 1'b0;
    end
  end

  // Merge uses the registered buffer, so a flush in this same cycle still supplies its bytes.
  logic hit;
  assign hit = rd_phase & buf_valid & (buf_addr == rd_addr);

  always_comb begin
    rdata = ram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (hit && buf_lanes[i]) rdata[8*i +: 8] = buf_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/ahb_fpga_ram_if.sv
// Zero-wait-state AHB-Lite slave in front of the FPGA block-RAM wrapper's SRAM-style port.
// Optional address range check with two-cycle ERROR response: define AHB_RAM_RANGE_CHECK_EN.
module ahb_fpga_ram_if
  import ahb_ram_pkg::*;
#(
  parameter int AW         = 16,
  parameter int ADDR_LIMIT = 'h8000
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic          HREADY,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [AW-1:0] HADDR,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic [AW-3:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWEN,
  output logic          SRAMCS,
  input  logic [31:0]   SRAMRDATA
);

`ifdef AHB_RAM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif
  localparam logic [AW:0] LIMIT = (AW+1)'(ADDR_LIMIT);

  logic acc, in_range, rd_go, wr_go;
  logic aph_wr, aph_rd;
  logic [AW-3:0] aph_addr;
  logic [3:0] aph_lanes;
  logic buf_valid;
  logic [AW-3:0] buf_addr;
  logic [3:0] buf_lanes;
  logic [31:0] buf_data;

  assign acc      = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign in_range = !RANGE_EN || ({1'b0, HADDR} < LIMIT);
  assign rd_go    = acc & ~HWRITE & in_range;
  assign wr_go    = acc & HWRITE & in_range;

  // Address phase -> data phase boundary
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      aph_wr    <= 1'b0;
      aph_rd    <= 1'b0;
      aph_addr  <= '0;
      aph_lanes <= '0;
    end else if (HREADY) begin
      aph_wr    <= wr_go;
      aph_rd    <= rd_go;
      aph_addr  <= acc ? HADDR[AW-1:2] : '0;
      aph_lanes <= acc ? lane_decode(HSIZE, HADDR[1:0]) : '0;
    end
  end

  // One RAM access per cycle: a new read wins, then a posted write, then the live write.
  always_comb begin
    SRAMADDR  = HADDR[AW-1:2];
    SRAMWDATA = HWDATA;
    SRAMWEN   = 4'b0000;
    SRAMCS    = 1'b0;
    if (rd_go) begin
      SRAMCS = 1'b1;
    end else if (buf_valid) begin
      SRAMADDR  = buf_addr;
      SRAMWDATA = buf_data;
      SRAMWEN   = buf_lanes;
      SRAMCS    = 1'b1;
    end else if (aph_wr) begin
      SRAMADDR  = aph_addr;
      SRAMWEN   = aph_lanes;
      SRAMCS    = 1'b1;
    end
  end

  ahb_ram_wbuf #(.AW(AW)) u_wbuf (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .load      (aph_wr & rd_go),
    .flush     (buf_valid & ~rd_go),
    .ld_addr   (aph_addr),
    .ld_lanes  (aph_lanes),
    .ld_data   (HWDATA),
    .rd_phase  (aph_rd),
    .rd_addr   (aph_addr),
    .ram_rdata (SRAMRDATA),
    .buf_valid (buf_valid),
    .buf_addr  (buf_addr),
    .buf_lanes (buf_lanes),
    .buf_data  (buf_data),
    .rdata     (HRDATA)
  );

`ifdef AHB_RAM_RANGE_CHECK_EN
  resp_state_e state;
  logic ready_r, resp_r;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_OKAY;
      ready_r <= 1'b1;
      resp_r  <= RESP_OKAY;
    end else begin
      case (state)
        ST_ERR1: begin
          state   <= ST_ERR2;
          ready_r <= 1'b1;
          resp_r  <= RESP_ERROR;
        end
        default: begin
          if (acc && !in_range) begin
            state   <= ST_ERR1;
            ready_r <= 1'b0;
            resp_r  <= RESP_ERROR;
          end else begin
            state   <= ST_OKAY;
            ready_r <= 1'b1;
            resp_r  <= RESP_OKAY;
          end
        end
      endcase
    end
  end

  assign HREADYOUT = ready_r;
  assign HRESP     = resp_r;
`else
  assign HREADYOUT = 1'b1;
  assign HRESP     = RESP_OKAY;
`endif

  // A write's address-phase cycle never accepts a read, so the buffer always drains before its data phase.
  a_buf_free_at_write: assert property (@(posedge HCLK) disable iff (!HRESETn) aph_wr |-> !buf_valid);

endmodule

// File: tb/tb_ahb_fpga_ram_if.sv
// Self-checking bench for ahb_fpga_ram_if: word-level reference memory plus directed literal checks.
`timescale 1ns/1ps
module tb_ahb_fpga_ram_if;
  localparam int AW         = 16;
  localparam int ADDR_LIMIT = 'h8000;
  localparam int WORDS      = 1 << (AW-2);
`ifdef AHB_RAM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          HSEL = 1'b0;
  logic          HWRITE = 1'b0;
  logic [1:0]    HTRANS = 2'b00;
  logic [2:0]    HSIZE = 3'd0;
  logic [AW-1:0] HADDR = '0;
  logic [31:0]   HWDATA = '0;
  logic          HREADYOUT, HRESP, SRAMCS;
  logic [31:0]   HRDATA, SRAMWDATA, SRAMRDATA;
  logic [AW-3:0] SRAMADDR;
  logic [3:0]    SRAMWEN;

  logic [31:0] ram     [WORDS];
  logic [31:0] ref_mem [WORDS];
  int checks = 0;
  int errors = 0;
  logic [31:0] pend_wdata = 32'h0;

  always #5 HCLK = ~HCLK;

  ahb_fpga_ram_if #(.AW(AW), .ADDR_LIMIT(ADDR_LIMIT)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HREADY    (HREADYOUT),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .SRAMADDR  (SRAMADDR),
    .SRAMWDATA (SRAMWDATA),
    .SRAMWEN   (SRAMWEN),
    .SRAMCS    (SRAMCS),
    .SRAMRDATA (SRAMRDATA)
  );

  // Block RAM behind the wrapper: synchronous, read data one cycle after the access.
  initial begin
    for (int i = 0; i < WORDS; i++) ram[i] <= 32'h0;
    ram[8] <= 32'h11111111;
  end
  always @(posedge HCLK) begin
    if (SRAMCS) begin
      for (int i = 0; i < 4; i++)
        if (SRAMWEN[i]) ram[SRAMADDR][8*i +: 8] <= SRAMWDATA[8*i +: 8];
      SRAMRDATA <= ram[SRAMADDR];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lanes_of(input logic [2:0] size, input logic [AW-1:0] a);
    if (size == 3'd0) return 4'b0001 << a[1:0];
    if (size == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Reference: memory image updated when each write's data phase completes; reads see it in their data phase.
  logic          m_wr = 1'b0, m_rd = 1'b0, m_acc, m_bad;
  logic [AW-3:0] m_word = '0;
  logic [3:0]    m_lanes = '0;
  int            err_left = 0;

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      // Reset drops any posted write, so the RAM contents become the truth again.
      m_wr = 1'b0;
      m_rd = 1'b0;
      err_left = 0;
      for (int i = 0; i < WORDS; i++) ref_mem[i] = ram[i];
    end else begin
      if (m_wr)
        for (int i = 0; i < 4; i++)
          if (m_lanes[i]) ref_mem[m_word][8*i +: 8] = HWDATA[8*i +: 8];
      m_acc   = HSEL && HREADYOUT && HTRANS[1];
      m_bad   = RANGE_EN && m_acc && (int'(HADDR) >= ADDR_LIMIT);
      m_wr    = m_acc && HWRITE && !m_bad;
      m_rd    = m_acc && !HWRITE && !m_bad;
      m_word  = HADDR[AW-1:2];
      m_lanes = lanes_of(HSIZE, HADDR);
      if (m_bad) err_left = 2;
      else if (err_left > 0) err_left = err_left - 1;
    end
  end

  always @(negedge HCLK) begin
    chk("hreadyout", 32'(HREADYOUT), (err_left == 2) ? 32'd0 : 32'd1);
    chk("hresp", 32'(HRESP), (err_left != 0) ? 32'd1 : 32'd0);
    if (HRESETn && m_rd) chk("hrdata_model", HRDATA, ref_mem[m_word]);
  end

  task automatic bus(input logic sel, input logic [1:0] trans, input logic wr,
                     input logic [2:0] size, input logic [AW-1:0] addr, input logic [31:0] wdata);
    @(posedge HCLK);
    #1;
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = wr;
    HSIZE  = size;
    HADDR  = addr;
    HWDATA = pend_wdata;
    pend_wdata = wr ? wdata : 32'hDEADBEEF;
    @(negedge HCLK);
  endtask

  task automatic idle();
    bus(1'b0, 2'b00, 1'b0, 3'd0, '0, 32'h0);
  endtask
  task automatic do_wr(input logic [2:0] size, input logic [AW-1:0] addr, input logic [31:0] data);
    bus(1'b1, 2'b10, 1'b1, size, addr, data);
  endtask
  task automatic do_rd(input logic [AW-1:0] addr);
    bus(1'b1, 2'b10, 1'b0, 3'd2, addr, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, including a read accepted while reset is held
    @(negedge HCLK);
    @(negedge HCLK);
    chk("rst_wen", 32'(SRAMWEN), 32'h0);
    chk("rst_cs_idle", 32'(SRAMCS), 32'h0);
    do_rd(16'h0010);
    chk("rst_cs_read", 32'(SRAMCS), 32'h1);
    chk("rst_wen_read", 32'(SRAMWEN), 32'h0);
    idle();
    chk("rst_hrdata", HRDATA, 32'h0);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // Byte write into a zero word
    do_wr(3'd0, 16'h0013, 32'hAB000000);
    idle();
    chk("byte_wen", 32'(SRAMWEN), 32'h8);
    chk("byte_addr", 32'(SRAMADDR), 32'h4);
    do_rd(16'h0010);
    idle();
    chk("byte_rd", HRDATA, 32'hAB000000);

    // Word write then read
    do_wr(3'd2, 16'h0010, 32'h12345678);
    idle();
    chk("word_wen", 32'(SRAMWEN), 32'hF);
    do_rd(16'h0010);
    idle();
    chk("word_rd", HRDATA, 32'h12345678);

    // Halfword write immediately followed by a word read of the same word
    do_wr(3'd1, 16'h0022, 32'h55550000);
    do_rd(16'h0020);
    chk("hw_read_wins_cs", 32'(SRAMCS), 32'h1);
    chk("hw_read_wins_wen", 32'(SRAMWEN), 32'h0);
    idle();
    chk("hw_merge", HRDATA, 32'h55551111);
    chk("hw_flush_wen", 32'(SRAMWEN), 32'hC);
    chk("hw_flush_addr", 32'(SRAMADDR), 32'h8);

    // Posted full word, merged read, flush in the idle cycle
    do_wr(3'd2, 16'h0020, 32'hCAFEF00D);
    do_rd(16'h0020);
    idle();
    chk("post_merge", HRDATA, 32'hCAFEF00D);
    chk("post_flush_wen", 32'(SRAMWEN), 32'hF);
    idle();
    chk("post_done_cs", 32'(SRAMCS), 32'h0);

    // BUSY and deselected transfers touch nothing
    bus(1'b1, 2'b01, 1'b1, 3'd2, 16'h0030, 32'h99999999);
    chk("busy_cs", 32'(SRAMCS), 32'h0);
    idle();
    chk("busy_dp_wen", 32'(SRAMWEN), 32'h0);

    // Alternating write/read stream, then read/read and write/write runs
    for (int k = 0; k < 10; k++) begin
      do_wr(3'd2, AW'(16'h0100 + 4*k), 32'hA5000000 + 32'(k) * 32'h00010101);
      do_rd(AW'(16'h0100 + 4*k));
    end
    for (int k = 0; k < 10; k++) do_rd(AW'(16'h0100 + 4*k));
    do_wr(3'd2, 16'h0200, 32'h01020304);
    do_wr(3'd2, 16'h0204, 32'h05060708);
    do_rd(16'h0200);
    do_rd(16'h0204);
    idle();
    chk("ww_rd2", HRDATA, 32'h05060708);
    idle();

`ifdef AHB_RAM_RANGE_CHECK_EN
    do_rd(16'h8000);
    chk("range_cs", 32'(SRAMCS), 32'h0);
    idle();
    chk("range_ready1", 32'(HREADYOUT), 32'h0);
    chk("range_resp1", 32'(HRESP), 32'h1);
    idle();
    chk("range_ready2", 32'(HREADYOUT), 32'h1);
    chk("range_resp2", 32'(HRESP), 32'h1);
    idle();
    chk("range_okay", 32'(HRESP), 32'h0);
`endif

    // Reset while a write sits in the buffer
    do_wr(3'd2, 16'h0040, 32'h77778888);
    do_rd(16'h0044);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    HSEL = 1'b0;
    HTRANS = 2'b00;
    @(negedge HCLK);
    chk("midrst_wen", 32'(SRAMWEN), 32'h0);
    chk("midrst_cs", 32'(SRAMCS), 32'h0);
    @(negedge HCLK);
    chk("midrst_wen2", 32'(SRAMWEN), 32'h0);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("postrst_wen", 32'(SRAMWEN), 32'h0);
    end
    chk("discarded_write", ram[16], 32'h0);

    // Final RAM image must equal the reference image
    idle();
    for (int i = 0; i < 136; i++) chk("ram_image", ram[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_fpga_ram_if.md
Name: ahb_fpga_ram_if

Overview:
- AHB-Lite slave that drives the FPGA block-RAM wrapper's SRAM-style port: word address, 4 byte-lane write enables, chip select, and 32-bit write/read data.
- Zero-wait-state reads and writes.
- Writes that collide with a read are posted into a one-entry write buffer.
- Read-after-write hazards are resolved by byte-merging buffered data into HRDATA.
- Sits between the AHB interconnect and the RAM wrapper.

Parameters:
- AW, 16, byte address width; RAM port address is HADDR[AW-1:2].
- ADDR_LIMIT, 'h8000, first illegal byte address; used only with AHB_RAM_RANGE_CHECK_EN.

Ports:
- HCLK  in  1  bus clock; also clocks the RAM.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HREADY  in  1  bus ready (previous transfer complete).
- HTRANS  in  2  transfer type; bit1 set = NONSEQ/SEQ.
- HSIZE  in  3  transfer size.
- HWRITE  in  1  write when 1.
- HADDR  in  AW  byte address.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data.
- SRAMADDR  out  AW-2  RAM word address.
- SRAMWDATA  out  32  RAM write data.
- SRAMWEN  out  4  per-byte write enables.
- SRAMCS  out  1  RAM enable.
- SRAMRDATA  in  32  RAM read data, one cycle after a read with SRAMCS=1.

Behaviour:
- Accept = HSEL & HREADY & HTRANS[1]. Accepted read = accept & !HWRITE; accepted write = accept & HWRITE.
- Lane decode: HSIZE=0 selects lane HADDR[1:0]; HSIZE=1 selects lanes {1,0} when HADDR[1]=0, else {3,2}; HSIZE>=2 selects all 4 lanes.
- Registers:
  - Address-phase regs: aph_wr, aph_rd, aph_addr, aph_lanes. Loaded every cycle HREADY=1; cleared when no accept.
  - Write buffer: buf_valid, buf_addr, buf_lanes, buf_data.
- RAM port priority each cycle, one access:
  1. Accepted read: SRAMADDR=HADDR[AW-1:2], SRAMCS=1, SRAMWEN=0. Combinational, so data returns in the data phase.
  2. buf_valid: write the buffer (SRAMADDR=buf_addr, SRAMWDATA=buf_data, SRAMWEN=buf_lanes, SRAMCS=1). Clear buf_valid at the clock edge.
  3. aph_wr (write data phase): direct write with aph_addr, HWDATA, aph_lanes.
  4. Otherwise SRAMCS=0, SRAMWEN=0.
- If a write data phase coincides with an accepted read, load the buffer at the edge: buf_addr/lanes from aph, buf_data=HWDATA, buf_valid=1.
- Invariant: buf_valid=0 at every write data phase. The preceding write address-phase cycle always frees the port. Assert it.
- Read data phase (aph_rd): for each lane i, HRDATA byte i = buf_data byte i if buf_valid & buf_addr==aph_addr & buf_lanes[i]; otherwise SRAMRDATA byte i. A flush in the same cycle does not affect the merge.
- Back-to-back write/write, read/read and write/read all complete with zero wait states. HREADYOUT=1 and HRESP=0 always (without the macro).
- IDLE/BUSY or HSEL=0 transfers cause no RAM access and give an OKAY response.
- Reset (any time, including mid-transfer):
  - All registers clear; a pending buffered write is discarded.
  - HREADYOUT=1, HRESP=0, SRAMWEN=0. SRAMCS=0 unless a read is accepted.
  - HRDATA follows SRAMRDATA.

Optional Feature:
- Macro AHB_RAM_RANGE_CHECK_EN.
- With it defined, an accepted transfer with HADDR>=ADDR_LIMIT:
  - makes no RAM access and does not load the buffer;
  - gets a two-cycle ERROR response: data phase cycle 1 HREADYOUT=0, HRESP=1; cycle 2 HREADYOUT=1, HRESP=1;
  - state machine OKAY -> ERR1 -> ERR2 -> OKAY.
  - A buffered write may flush during ERR1/ERR2.
- Without the macro: no range check; HREADYOUT tied 1, HRESP tied 0.

Decomposition:
- Shared package ahb_ram_pkg: HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), HSIZE encodings, RESP_OKAY/RESP_ERROR, lane-decode function (HSIZE, HADDR[1:0]) -> 4-bit lanes.
- One sub-module: ahb_ram_wbuf. It holds the buffer registers, load/flush control and the HRDATA byte-merge mux.

Test Plan:
- Word write 'h12345678 to 'h0010, then read 'h0010 -> SRAMWEN=4'hF in the write data phase; HRDATA='h12345678; no wait states.
- Byte write 'hAB to 'h0013 (HSIZE=0) over word 'h0 -> SRAMWEN=4'b1000; read returns 'hAB000000.
- Write 'hCAFEF00D to 'h0020 with a read of 'h0020 in the next address phase -> buffer loaded; HRDATA='hCAFEF00D via merge; buffer flushed in the following idle cycle with SRAMWEN=4'hF.
- Halfword write 'h5555 to 'h0022 then an immediate read of word 'h0020 (RAM holds 'h11111111) -> HRDATA='h55551111.
- Continuous alternating W/R to different words for 20 cycles -> HREADYOUT never low; every word read back equals the value last written; buffer invariant holds.
- With AHB_RAM_RANGE_CHECK_EN, read of 'h8000 -> HREADYOUT 0 then 1 with HRESP=1 in both cycles; SRAMCS=0. Assert HRESETn mid-buffer -> SRAMWEN stays 0 afterwards.
